divisor_sequencial: RTL and testbench



---
 rtl/divisor_sequencial.sv | 118 +++++++++++
 tb/tb_divisor_sequencial.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_sequencial.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Divide-by-zero short-circuits to q = all ones, r = a with div_zero flagged one cycle after acceptance.
module divisor_sequencial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  dvd_reg;
    logic [WIDTH-1:0]  div_reg;
    logic [WIDTH-1:0]  rem_reg;
    logic [CW-1:0]     cnt_reg;
    logic [WIDTH-1:0]  q_reg;
    logic [WIDTH-1:0]  r_reg;
    logic              dz_reg;
    logic              done_reg;
    logic              dz_pend_reg;

    logic              accept;
    logic              last_iter;
    logic [WIDTH-1:0]  rem_shift;
    logic [WIDTH:0]    trial;
    logic [WIDTH-1:0]  rem_next;
    logic [WIDTH-1:0]  dvd_next;

    assign accept    = start && (state_reg == IDLE);
    assign last_iter = (state_reg == CALC) && (cnt_reg == CW'(WIDTH - 1));

    // The dividend register doubles as the quotient register: each shift
    // pushes a dividend bit out of the MSB and a quotient bit into the LSB.
    assign rem_shift = {rem_reg[WIDTH-2:0], dvd_reg[WIDTH-1]};
    assign trial     = {1'b0, rem_shift} - {1'b0, div_reg};
    assign rem_next  = trial[WIDTH] ? rem_shift : trial[WIDTH-1:0];
    assign dvd_next  = {dvd_reg[WIDTH-2:0], ~trial[WIDTH]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start && (b != '0)) state_next = CALC;
            CALC: if (last_iter)          state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_reg     <= '0;
            div_reg     <= '0;
            rem_reg     <= '0;
            cnt_reg     <= '0;
            q_reg       <= '0;
            r_reg       <= '0;
            dz_reg      <= 1'b0;
            done_reg    <= 1'b0;
            dz_pend_reg <= 1'b0;
        end else begin
            done_reg    <= 1'b0;
            dz_pend_reg <= 1'b0;
            if (accept) begin
                dvd_reg     <= a;
                div_reg     <= b;
                rem_reg     <= '0;
                cnt_reg     <= '0;
                dz_pend_reg <= (b == '0);
            end else if (state_reg == CALC) begin
                dvd_reg <= dvd_next;
                rem_reg <= rem_next;
                cnt_reg <= cnt_reg + CW'(1);
                if (last_iter) begin
                    q_reg    <= dvd_next;
                    r_reg    <= rem_next;
                    dz_reg   <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
            // dvd_reg still holds the zero-divisor operation's dividend here,
            // even if a new operation is being accepted on this same edge.
            if (dz_pend_reg) begin
                q_reg    <= '1;
                r_reg    <= dvd_reg;
                dz_reg   <= 1'b1;
                done_reg <= 1'b1;
            end
        end
    end

    assign busy     = (state_reg == CALC);
    assign done     = done_reg;
    assign q        = q_reg;
    assign r        = r_reg;
    assign div_zero = dz_reg;

endmodule

// File: tb/tb_divisor_sequencial.sv
// Self-checking bench for divisor_sequencial: directed vector table, multi-cycle
// corner sequences and randomized operands against an arithmetic reference model.
module tb_divisor_sequencial;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         div_zero;

    int pass_cnt  = 0;
    int total_cnt = 0;

    divisor_sequencial #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .q        (q),
        .r        (r),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         edz;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else
            pass_cnt++;
    endtask

    // Launch one operation and wait (bounded) for its done pulse.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          output logic [W-1:0] gq, output logic [W-1:0] gr,
                          output logic gdz, output int lat);
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'(tb_v != '0));
        lat = -1; gq = '0; gr = '0; gdz = 1'b0;
        for (int n = 1; n <= 2 * W + 4; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n; gq = q; gr = r; gdz = div_zero;
                break;
            end
        end
        if (lat < 0) begin
            check("done_timeout", 64'(0), 64'(1));
        end else begin
            @(negedge clk);
            check("done_pulse_width", 64'(done), 64'(0));
        end
    endtask

    // Reference: plain integer division; all-ones quotient and r=a when b is zero.
    task automatic check_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
        logic [W-1:0] gq, gr, eq, er;
        logic         gdz, edz;
        int           lat, elat;
        if (tb_v == 0) begin
            eq = '1; er = ta; edz = 1'b1; elat = 1;
        end else begin
            eq = W'(int'(ta) / int'(tb_v)); er = W'(int'(ta) % int'(tb_v)); edz = 1'b0; elat = W;
        end
        run_op(ta, tb_v, gq, gr, gdz, lat);
        $display("op a=%0d b=%0d -> q=%0d r=%0d dz=%0d lat=%0d", ta, tb_v, gq, gr, gdz, lat);
        check("q", 64'(gq), 64'(eq));
        check("r", 64'(gr), 64'(er));
        check("div_zero", 64'(gdz), 64'(edz));
        check("latency", 64'(lat), 64'(elat));
        if (tb_v != 0) begin
            check("invariant_qb_plus_r", 64'(int'(gq) * int'(tb_v) + int'(gr)), 64'(ta));
            check("invariant_r_lt_b", 64'(gr < tb_v), 64'(1));
        end
    endtask

    vec_t vecs[10];

    initial begin
        logic [W-1:0] ra, rb;
        logic [W-1:0] fq1, fr1, fq2, fr2;
        int ndone, t1, t2, busy_at_done;

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_q", 64'(q), 64'(0));
        check("reset_r", 64'(r), 64'(0));
        check("reset_div_zero", 64'(div_zero), 64'(0));
        rst = 1'b0;

        vecs[0] = '{va: 8'd100, vb: 8'd7,   eq: 8'd14,  er: 8'd2,  edz: 1'b0};
        vecs[1] = '{va: 8'd255, vb: 8'd1,   eq: 8'd255, er: 8'd0,  edz: 1'b0};
        vecs[2] = '{va: 8'd5,   vb: 8'd200, eq: 8'd0,   er: 8'd5,  edz: 1'b0};
        vecs[3] = '{va: 8'd0,   vb: 8'd9,   eq: 8'd0,   er: 8'd0,  edz: 1'b0};
        vecs[4] = '{va: 8'd77,  vb: 8'd0,   eq: 8'hFF,  er: 8'd77, edz: 1'b1};
        vecs[5] = '{va: 8'd9,   vb: 8'd3,   eq: 8'd3,   er: 8'd0,  edz: 1'b0};
        vecs[6] = '{va: 8'd13,  vb: 8'd13,  eq: 8'd1,   er: 8'd0,  edz: 1'b0};
        vecs[7] = '{va: 8'd0,   vb: 8'd0,   eq: 8'hFF,  er: 8'd0,  edz: 1'b1};
        vecs[8] = '{va: 8'd255, vb: 8'd255, eq: 8'd1,   er: 8'd0,  edz: 1'b0};
        vecs[9] = '{va: 8'd254, vb: 8'd255, eq: 8'd0,   er: 8'd254, edz: 1'b0};

        for (int i = 0; i < 10; i++) begin
            logic [W-1:0] gq, gr;
            logic         gdz;
            int           lat;
            run_op(vecs[i].va, vecs[i].vb, gq, gr, gdz, lat);
            $display("vec %0d a=%0d b=%0d -> q=%0d r=%0d dz=%0d lat=%0d",
                     i, vecs[i].va, vecs[i].vb, gq, gr, gdz, lat);
            check("vec_q", 64'(gq), 64'(vecs[i].eq));
            check("vec_r", 64'(gr), 64'(vecs[i].er));
            check("vec_div_zero", 64'(gdz), 64'(vecs[i].edz));
            check("vec_latency", 64'(lat), 64'(vecs[i].edz ? 1 : W));
        end

        // start pulses while busy must be ignored, not queued
        @(negedge clk);
        a = 8'd200; b = 8'd13; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; t1 = -1; fq1 = '0; fr1 = '0;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (done) begin
                ndone++; t1 = n; fq1 = q; fr1 = r;
            end
            if (n == 2 || n == 4) begin
                a = 8'd1; b = 8'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        $display("ignore-busy a=200 b=13 -> q=%0d r=%0d dones=%0d lat=%0d", fq1, fr1, ndone, t1);
        check("ignore_done_count", 64'(ndone), 64'(1));
        check("ignore_q", 64'(fq1), 64'(15));
        check("ignore_r", 64'(fr1), 64'(5));
        check("ignore_latency", 64'(t1), 64'(W));

        // back-to-back: start held through done, new operands presented in the done cycle
        @(negedge clk);
        a = 8'd50; b = 8'd6; start = 1'b1;
        @(negedge clk);
        ndone = 0; t1 = -1; t2 = -1; busy_at_done = -1;
        fq1 = '0; fr1 = '0; fq2 = '0; fr2 = '0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    t1 = n; fq1 = q; fr1 = r; busy_at_done = int'(busy);
                    a = 8'd81; b = 8'd9;
                end else begin
                    t2 = n; fq2 = q; fr2 = r;
                end
            end
            if (t1 > 0 && n == t1 + 1) start = 1'b0;
        end
        start = 1'b0;
        $display("back-to-back -> q1=%0d r1=%0d t1=%0d q2=%0d r2=%0d t2=%0d", fq1, fr1, t1, fq2, fr2, t2);
        check("b2b_done_count", 64'(ndone), 64'(2));
        check("b2b_q1", 64'(fq1), 64'(8));
        check("b2b_r1", 64'(fr1), 64'(2));
        check("b2b_t1", 64'(t1), 64'(W));
        check("b2b_busy_in_done_cycle", 64'(busy_at_done), 64'(0));
        check("b2b_q2", 64'(fq2), 64'(9));
        check("b2b_r2", 64'(fr2), 64'(0));
        check("b2b_t2", 64'(t2), 64'(2 * W + 1));

        // asynchronous reset in the middle of an iteration aborts it
        @(negedge clk);
        a = 8'd123; b = 8'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_q", 64'(q), 64'(0));
        check("abort_r", 64'(r), 64'(0));
        check("abort_div_zero", 64'(div_zero), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        $display("abort a=123 b=10 -> dones after reset=%0d", ndone);
        check("abort_no_done", 64'(ndone), 64'(0));
        check_op(8'd123, 8'd10);

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
            check_op(ra, rb);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
